rr_arbiter8: RTL and testbench

//   Round-robin arbiter that shares one resource among 8 requesters.

---
 rtl/rr_arbiter8.sv | 102 ++++++++++
 tb/tb_rr_arbiter8.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a rotating priority pointer and a per-grant hold limit.
// The owner index is decoded to a one-hot grant that is forced low whenever no grant is active.
module rr_arbiter8 #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;

    logic [7:0] req_rot;
    logic [2:0] win_off;
    logic [2:0] winner;
    logic       release_now;

    // req_rot[k] is the request of requester (ptr + k) mod 8, so bit 0 has top priority.
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
        assign req_rot[gi] = req[ptr_q + 3'(gi)];
    end

    always_comb begin
        win_off = '0;
        for (int k = 7; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off = 3'(k);
            end
        end
    end

    assign winner      = ptr_q + win_off;
    assign release_now = done || !req[idx_q] || (hold_cnt_q == HOLD_LAST) || !en;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (en && (req != 8'h00)) begin
                    state_d    = GRANT;
                    idx_d      = winner;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                    // A revocation by en=0 leaves the owner at the head of the queue.
                    if (en) begin
                        ptr_d = idx_q + 3'd1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt_vld = (state_q == GRANT);
    assign gnt_idx = idx_q;

    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
        assign gnt[gi] = gnt_vld && (idx_q == 3'(gi));
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios with literal expectations plus a
// per-cycle comparison against a queue-free behavioural model of the arbitration rules.
module tb_rr_arbiter8;

    localparam int HOLD_MAX = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [7:0] req = 8'hFF;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;

    int n_checks = 0;
    int n_fail   = 0;

    rr_arbiter8 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .gnt_idx(gnt_idx),
        .gnt_vld(gnt_vld)
    );

    always #5 clk = ~clk;

    // Model: owner is -1 when nobody holds the resource; held counts cycles granted so far.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_last  = 0;
    int m_held  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_last  = 0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            if (en && req != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % 8]) begin
                        m_owner = (m_ptr + k) % 8;
                    end
                end
                m_last = m_owner;
                m_held = 1;
            end
        end else begin
            if (done || !req[m_owner] || m_held == HOLD_MAX || !en) begin
                if (en) m_ptr = (m_owner + 1) % 8;
                m_owner = -1;
            end else begin
                m_held = m_held + 1;
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] e_gnt;
        e_gnt = (m_owner >= 0) ? (8'h01 << m_last) : 8'h00;
        check("model_gnt", gnt, e_gnt);
        check("model_idx", {5'd0, gnt_idx}, 8'(m_last));
        check("model_vld", {7'd0, gnt_vld}, {7'd0, m_owner >= 0});
        $display("cyc t=%0t rst=%b en=%b req=%h done=%b -> gnt=%h idx=%0d vld=%b",
                 $time, rst, en, req, done, gnt, gnt_idx, gnt_vld);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [7:0] e_gnt, input logic [2:0] e_idx,
                       input logic e_vld);
        check({name, "_gnt"}, gnt, e_gnt);
        check({name, "_idx"}, {5'd0, gnt_idx}, {5'd0, e_idx});
        check({name, "_vld"}, {7'd0, gnt_vld}, {7'd0, e_vld});
    endtask

    initial begin
        // 1: reset holds everything low despite full requests
        for (int i = 0; i < 3; i++) begin
            step(1);
            lit("t1_reset", 8'h00, 3'd0, 1'b0);
        end
        rst = 1'b0;
        req = 8'h00;
        step(2);
        lit("t1_idle", 8'h00, 3'd0, 1'b0);

        // 2: single requester 3, done on the second grant cycle
        req = 8'h08;
        step(1);
        lit("t2_g1", 8'h08, 3'd3, 1'b1);
        step(1);
        lit("t2_g2", 8'h08, 3'd3, 1'b1);
        done = 1'b1;
        step(1);
        lit("t2_rel", 8'h00, 3'd3, 1'b0);
        done = 1'b0;
        step(1);
        lit("t2_regrant", 8'h08, 3'd3, 1'b1);
        req = 8'h00;
        step(1);
        lit("t2_idle", 8'h00, 3'd3, 1'b0);

        // 3: all requesting from ptr=0, each grant 4 cycles then one idle cycle
        rst = 1'b1;
        #2;
        rst = 1'b0;
        req = 8'hFF;
        step(1);
        for (int g = 0; g < 9; g++) begin
            for (int c = 0; c < HOLD_MAX; c++) begin
                lit("t3_grant", 8'h01 << (g % 8), 3'(g % 8), 1'b1);
                step(1);
            end
            lit("t3_gap", 8'h00, 3'(g % 8), 1'b0);
            if (g == 8) req = 8'h40;
            step(1);
        end

        // 4: grant 6 moves ptr to 7; req 0x82 wraps 7 then 1
        lit("t4_g6", 8'h40, 3'd6, 1'b1);
        req = 8'h00;
        step(1);
        lit("t4_idle", 8'h00, 3'd6, 1'b0);
        req = 8'h82;
        step(1);
        lit("t4_g7", 8'h80, 3'd7, 1'b1);
        step(3);
        lit("t4_g7_last", 8'h80, 3'd7, 1'b1);
        step(1);
        lit("t4_gap", 8'h00, 3'd7, 1'b0);
        step(1);
        lit("t4_g1", 8'h02, 3'd1, 1'b1);
        req = 8'h00;
        step(1);
        lit("t4_end", 8'h00, 3'd1, 1'b0);

        // 5: en dropped during grant to 2; ptr must stay at 2
        req = 8'h04;
        step(1);
        lit("t5_g1", 8'h04, 3'd2, 1'b1);
        step(1);
        lit("t5_g2", 8'h04, 3'd2, 1'b1);
        en = 1'b0;
        step(1);
        lit("t5_revoke", 8'h00, 3'd2, 1'b0);
        req = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step(1);
            lit("t5_disabled", 8'h00, 3'd2, 1'b0);
        end
        en = 1'b1;
        req = 8'h0C;
        step(1);
        lit("t5_regrant", 8'h04, 3'd2, 1'b1);

        // 6: async reset mid-grant of 5, then restart from ptr=0
        req = 8'h00;
        step(1);
        req = 8'h20;
        step(1);
        lit("t6_g5", 8'h20, 3'd5, 1'b1);
        step(1);
        lit("t6_g5b", 8'h20, 3'd5, 1'b1);
        rst = 1'b1;
        req = 8'h21;
        #1;
        lit("t6_async", 8'h00, 3'd0, 1'b0);
        #1;
        rst = 1'b0;
        step(1);
        lit("t6_restart", 8'h01, 3'd0, 1'b1);

        // Extra vectors: mixed traffic checked by the model only
        for (int i = 0; i < 300; i++) begin
            req  = 8'($urandom);
            done = ($urandom_range(0, 5) == 0);
            en   = ($urandom_range(0, 9) != 0);
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
